// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch predictor counter state and BTB entry layout.
package rv32i_types;

    typedef enum logic [1:0] {
        strongly_not_taken = 2'b00,
        weakly_not_taken   = 2'b01,
        weakly_taken       = 2'b10,
        strongly_taken     = 2'b11
    } branch_predictor_state;

    // Widest possible tag (IDX_WIDTH = 0). Narrower tags are stored zero-extended.
    localparam int BTB_TAG_MAX = 30;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [31:0]            target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state logic for the branch history table.
module sat_counter2
    import rv32i_types::*;
(
    input  branch_predictor_state state_in,
    input  logic                  taken,
    output branch_predictor_state state_out
);

    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    always_comb begin
        state_out = state_in;
        case (state_in)
            strongly_not_taken: state_out = taken ? weakly_not_taken : strongly_not_taken;
            weakly_not_taken:   state_out = taken ? weakly_taken     : strongly_not_taken;
            weakly_taken:       state_out = taken ? strongly_taken   : weakly_not_taken;
            strongly_taken:     state_out = taken ? strongly_taken   : weakly_taken;
            default:            state_out = weakly_not_taken;
        endcase
    end

endmodule

// File: rtl/bht_btb_predictor.sv
// Fetch-stage predictor: 2-bit BHT plus tagged BTB, trained at branch resolution.
// Define BP_GSHARE_EN to hash the BHT index with a global history register.
module bht_btb_predictor
    import rv32i_types::*;
#(
    parameter int IDX_WIDTH = 6,
    parameter int GHR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_pc,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [IDX_WIDTH-1:0] pred_idx,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [IDX_WIDTH-1:0] upd_idx,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target
);

    localparam int ENTRIES = 1 << IDX_WIDTH;

    branch_predictor_state bht [ENTRIES];
    btb_entry_t            btb [ENTRIES];

    logic [IDX_WIDTH-1:0]  pc_idx;
    logic [IDX_WIDTH-1:0]  lookup_idx;
    logic [IDX_WIDTH-1:0]  upd_btb_idx;
    btb_entry_t            lookup_entry;
    branch_predictor_state lookup_ctr;
    branch_predictor_state upd_ctr_next;
    logic                  btb_hit;

    assign pc_idx      = if_pc[IDX_WIDTH+1:2];
    assign upd_btb_idx = upd_pc[IDX_WIDTH+1:2];

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr;

    assign lookup_idx = pc_idx ^ IDX_WIDTH'(ghr);

    // History advances only on resolved branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[GHR_WIDTH-2:0], upd_taken};
        end
    end
`else
    assign lookup_idx = pc_idx;
`endif

    // BTB is always indexed and tagged by the raw PC, even when the BHT is hashed.
    assign lookup_entry = btb[pc_idx];
    assign lookup_ctr   = bht[lookup_idx];
    assign btb_hit      = lookup_entry.valid
                       && (lookup_entry.tag == BTB_TAG_MAX'(if_pc[31:IDX_WIDTH+2]));

    assign pred_taken  = !rst && btb_hit && lookup_ctr[1];
    assign pred_target = (!rst && btb_hit) ? lookup_entry.target : 32'h0;
    assign pred_idx    = rst ? '0 : lookup_idx;

    sat_counter2 u_sat_counter2 (
        .state_in  (bht[upd_idx]),
        .taken     (upd_taken),
        .state_out (upd_ctr_next)
    );

    // NOTE: the arrays are plain flops rather than RAM, so every entry can be
    // cleared by a single-cycle reset; this loop would not map onto a memory macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= weakly_not_taken;
                btb[i] <= '0;
            end
        end else if (upd_valid) begin
            bht[upd_idx] <= upd_ctr_next;
            if (upd_taken) begin
                btb[upd_btb_idx] <= '{valid:  1'b1,
                                      tag:    BTB_TAG_MAX'(upd_pc[31:IDX_WIDTH+2]),
                                      target: upd_target};
            end
        end
    end

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a table-level model.
module tb_bht_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic [31:0] upd_target;

    int checks = 0;
    int errors = 0;

    // Reference model: counter value 0..3, BTB valid/tag/target, history as an int.
    int          m_ctr [64];
    bit          m_valid [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;

    bht_btb_predictor #(.IDX_WIDTH(6), .GHR_WIDTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_idx    (pred_idx),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3f);
    endfunction

    function automatic int m_bht_idx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return m_pc_idx(pc) ^ m_ghr;
`else
        return m_pc_idx(pc);
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[i]   = 1;
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'h0;
        end
        m_ghr = 0;
    endtask

    // One clock: drive, check at the falling edge against pre-update model, then train.
    task automatic cycle(input bit r, input logic [31:0] pc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
        int          bi;
        int          pi;
        bit          hit;
        logic [31:0] exp_tgt;
        bit          exp_taken;
        int          exp_idx;
        rst        = r;
        if_pc      = pc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_idx    = 6'(m_bht_idx(upc));
        upd_taken  = ut;
        upd_target = utgt;
        @(negedge clk);
        bi  = m_bht_idx(pc);
        pi  = m_pc_idx(pc);
        hit = m_valid[pi] && (m_tag[pi] == (pc >> 8));
        if (r) begin
            exp_taken = 1'b0;
            exp_tgt   = 32'h0;
            exp_idx   = 0;
        end else begin
            exp_taken = hit && (m_ctr[bi] >= 2);
            exp_tgt   = hit ? m_tgt[pi] : 32'h0;
            exp_idx   = bi;
        end
        check("pred_taken",  {31'b0, pred_taken}, {31'b0, exp_taken});
        check("pred_target", pred_target, exp_tgt);
        check("pred_idx",    {26'b0, pred_idx}, 32'(exp_idx));
        @(posedge clk);
        if (r) begin
            m_reset();
        end else if (uv) begin
            bi = int'(upd_idx);
            pi = m_pc_idx(upc);
            if (ut) begin
                if (m_ctr[bi] < 3) m_ctr[bi]++;
                m_valid[pi] = 1'b1;
                m_tag[pi]   = upc >> 8;
                m_tgt[pi]   = utgt;
            end else begin
                if (m_ctr[bi] > 0) m_ctr[bi]--;
            end
            m_ghr = ((m_ghr << 1) | int'(ut)) & 32'h3f;
        end
        #1;
    endtask

    localparam logic [31:0] PC_A  = 32'h6000_0010;
    localparam logic [31:0] PC_B  = 32'h6000_0110;
    localparam logic [31:0] TGT_A = 32'h6000_0040;
    localparam logic [31:0] TGT_B = 32'h6000_0200;

    initial begin
        logic [23:0] tags [4];
        logic [31:0] rpc;
        logic [31:0] rupc;
        tags[0] = 24'h600000;
        tags[1] = 24'h600001;
        tags[2] = 24'h123456;
        tags[3] = 24'h600002;
        m_reset();

        // Reset, then a cold lookup.
        cycle(1, PC_A, 1, PC_A, 1, TGT_A);
        cycle(1, PC_A, 0, 0, 0, 0);
        cycle(0, PC_A, 0, 0, 0, 0);
        check("cold_idx",    {26'b0, pred_idx}, 32'h4);
        check("cold_taken",  {31'b0, pred_taken}, 32'h0);
        check("cold_target", pred_target, 32'h0);

        // Two taken updates: 01 -> 10 -> 11.
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
        check("trained_taken",  {31'b0, pred_taken}, 32'h1);
        check("trained_target", pred_target, TGT_A);

        // Saturating down: 11 -> 10 -> 01 -> 00, and one more stays at 00.
        for (int i = 0; i < 4; i++) cycle(0, PC_A, 1, PC_A, 0, 0);
        cycle(0, PC_A, 0, 0, 0, 0);
        check("sat_lo_taken",  {31'b0, pred_taken}, 32'h0);
        check("sat_lo_target", pred_target, TGT_A);
        // From 00 one taken gives 01 (still not taken), a second gives 10.
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        check("sat_lo_plus1", {31'b0, pred_taken}, 32'h0);
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        check("sat_lo_plus2", {31'b0, pred_taken}, 32'h1);
`endif

        // Alias: same index, new tag, overwrites the BTB entry.
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 1, PC_B, 1, TGT_B);
        cycle(0, PC_A, 0, 0, 0, 0);
        check("alias_old_taken",  {31'b0, pred_taken}, 32'h0);
        check("alias_old_target", pred_target, 32'h0);
        cycle(0, PC_B, 0, 0, 0, 0);
        check("alias_new_target", pred_target, TGT_B);

        // Same-cycle update/lookup: old value now, new value next cycle.
`ifndef BP_GSHARE_EN
        check("bypass_before", {31'b0, pred_taken}, 32'h1);
        cycle(0, PC_B, 1, PC_B, 0, 0);
        cycle(0, PC_B, 1, PC_B, 0, 0);
        check("bypass_after", {31'b0, pred_taken}, 32'h0);
`else
        cycle(0, PC_B, 1, PC_B, 0, 0);
        cycle(0, PC_B, 1, PC_B, 0, 0);
`endif

        // Mid-run reset discards training.
        for (int i = 0; i < 3; i++) cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(1, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 0, 0, 0, 0);
        check("post_rst_taken",  {31'b0, pred_taken}, 32'h0);
        check("post_rst_target", pred_target, 32'h0);

`ifdef BP_GSHARE_EN
        // History 000011 hashes PC_A's index 4 to 7.
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 1, PC_A, 1, TGT_A);
        cycle(0, PC_A, 0, 0, 0, 0);
        check("gshare_idx", {26'b0, pred_idx}, 32'h7);
`endif

        // Random traffic over a few tags so hits and aliases are frequent.
        for (int n = 0; n < 3000; n++) begin
            rpc  = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 63)), 2'b00};
            rupc = ($urandom_range(0, 1) == 1) ? rpc
                 : {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 63)), 2'b00};
            cycle(($urandom_range(0, 99) < 2), rpc, $urandom_range(0, 1) == 1, rupc,
                  $urandom_range(0, 1) == 1, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
